// File: rtl/singing_fpga_sweep_top.sv
// singing_fpga_sweep_top
//   UART-controlled tone sweeper. The host sends 16-bit tuning words as two
//   bytes (high, then low). A sweep engine glides the active tuning word
//   toward each new target. A phase accumulator turns the active word into a
//   square wave on the header pin. Each completed word is echoed back as
//   {0xAC, hi, lo}.
//
// Ports
//   M_CLK_OSC     in   single system clock
//   M_RESET_B     in   synchronous reset, active high
//   FTDI_BDBUS_0  in   UART RX from host (asynchronous, idle high)
//   FTDI_BDBUS_1  out  UART TX to host (idle high)
//   M_HEADER      out  square-wave tone
//   M_LED_0       out  toggles on every byte received with a good stop bit
//   M_LED_1       out  tone active (current word != 0)
//   M_LED_2       out  sweep in progress (current != target)
module singing_fpga_sweep_top #(
    parameter int CLK_HZ       = 48_000_000,
    parameter int BAUD_DIV     = 833,
    parameter int ACC_W        = 24,
    parameter int SWEEP_TICK   = 48000,
    parameter int SWEEP_STEP   = 16,
    parameter int WORD_TIMEOUT = 1048576
) (
    input  logic M_CLK_OSC,
    input  logic M_RESET_B,
    input  logic FTDI_BDBUS_0,
    output logic FTDI_BDBUS_1,
    output logic M_HEADER,
    output logic M_LED_0,
    output logic M_LED_1,
    output logic M_LED_2
);

    localparam int BAUD_W = $clog2(BAUD_DIV + 1);
    localparam int TICK_W = $clog2(SWEEP_TICK + 1);
    localparam int TO_W   = $clog2(WORD_TIMEOUT + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SWEEP_TICK - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(WORD_TIMEOUT - 1);
    localparam logic [15:0]       STEP      = 16'(SWEEP_STEP);
    localparam logic [7:0]        ECHO_TAG  = 8'hAC;

    if (BAUD_DIV < 4 || CLK_HZ < 2 * BAUD_DIV || ACC_W < 16 ||
        SWEEP_TICK < 1 || WORD_TIMEOUT < 1) begin : g_param_check
        $error("singing_fpga_sweep_top: unsupported parameter set");
    end

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic       {TX_IDLE, TX_BUSY} tx_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e         rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_valid_q, rx_valid_d;

    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [15:0]       target_q, target_d;
    logic              led0_q, led0_d;
    logic              word_done;

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [15:0]       current_q, current_d;
    logic [15:0]       sweep_diff;
    logic              tgt_above;

    logic [ACC_W-1:0]  acc_q, acc_d;

    tx_state_e         tx_state_q, tx_state_d;
    logic [BAUD_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [1:0]        tx_idx_q, tx_idx_d;
    logic [9:0]        tx_shift_q, tx_shift_d;
    logic [7:0]        tx_hi_q, tx_hi_d;
    logic [7:0]        tx_lo_q, tx_lo_d;
    logic              pend_valid_q, pend_valid_d;
    logic [7:0]        pend_hi_q, pend_hi_d;
    logic [7:0]        pend_lo_q, pend_lo_d;
    logic              load_echo;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // Mid-start-bit re-check rejects glitches.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + BAUD_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + BAUD_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_valid_d = rx_sync_q;   // stop bit 0: framing error, drop
                end else begin
                    rx_cnt_d = rx_cnt_q + BAUD_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Word assembly (rx_shift_q holds the byte while rx_valid_q is high)
    // ------------------------------------------------------------------
    assign word_done = rx_valid_q & phase_q;

    always_comb begin
        phase_d  = phase_q;
        hi_d     = hi_q;
        to_cnt_d = to_cnt_q;
        target_d = target_q;
        led0_d   = led0_q;
        if (rx_valid_q) begin
            led0_d = ~led0_q;
            if (!phase_q) begin
                phase_d  = 1'b1;
                hi_d     = rx_shift_q;
                to_cnt_d = '0;
            end else begin
                phase_d  = 1'b0;
                target_d = {hi_q, rx_shift_q};
            end
        end else if (phase_q) begin
            if (to_cnt_q == TO_LAST) phase_d  = 1'b0;
            else                     to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sweep engine: uses target_q, so a word landing on a tick edge is
    // seen by the following tick.
    // ------------------------------------------------------------------
    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        tgt_above  = (target_q >= current_q);
        sweep_diff = tgt_above ? (target_q - current_q) : (current_q - target_q);
        current_d  = current_q;
        if (tick) begin
            if (sweep_diff <= STEP) current_d = target_q;
            else if (tgt_above)     current_d = current_q + STEP;
            else                    current_d = current_q - STEP;
        end
    end

    // ------------------------------------------------------------------
    // Oscillator
    // ------------------------------------------------------------------
    always_comb begin
        acc_d = (current_q == '0) ? '0 : acc_q + ACC_W'(current_q);
    end

    // ------------------------------------------------------------------
    // Echo transmitter with one overwrite-on-arrival pending slot
    // ------------------------------------------------------------------
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_bit_d     = tx_bit_q;
        tx_idx_d     = tx_idx_q;
        tx_shift_d   = tx_shift_q;
        tx_hi_d      = tx_hi_q;
        tx_lo_d      = tx_lo_q;
        pend_valid_d = pend_valid_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        load_echo    = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                if (pend_valid_q) load_echo = 1'b1;
            end
            TX_BUSY: begin
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        if (tx_idx_q == 2'd2) begin
                            if (pend_valid_q) begin
                                load_echo = 1'b1;
                            end else begin
                                tx_state_d = TX_IDLE;
                                tx_shift_d = '1;
                            end
                        end else begin
                            tx_idx_d   = tx_idx_q + 2'd1;
                            tx_bit_d   = '0;
                            tx_shift_d = {1'b1, (tx_idx_q == 2'd0) ? tx_hi_q : tx_lo_q, 1'b0};
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + BAUD_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        if (load_echo) begin
            tx_state_d   = TX_BUSY;
            tx_cnt_d     = '0;
            tx_bit_d     = '0;
            tx_idx_d     = '0;
            tx_hi_d      = pend_hi_q;
            tx_lo_d      = pend_lo_q;
            tx_shift_d   = {1'b1, ECHO_TAG, 1'b0};
            pend_valid_d = 1'b0;
        end

        // A new word always wins the slot, even over a same-cycle load.
        if (word_done) begin
            pend_valid_d = 1'b1;
            pend_hi_d    = hi_q;
            pend_lo_d    = rx_shift_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge M_CLK_OSC) begin
        if (M_RESET_B) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_valid_q   <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            to_cnt_q     <= '0;
            target_q     <= '0;
            led0_q       <= 1'b0;
            tick_cnt_q   <= '0;
            current_q    <= '0;
            acc_q        <= '0;
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_idx_q     <= '0;
            tx_shift_q   <= '1;
            tx_hi_q      <= '0;
            tx_lo_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_hi_q    <= '0;
            pend_lo_q    <= '0;
        end else begin
            rx_meta_q    <= FTDI_BDBUS_0;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_valid_q   <= rx_valid_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            to_cnt_q     <= to_cnt_d;
            target_q     <= target_d;
            led0_q       <= led0_d;
            tick_cnt_q   <= tick_cnt_d;
            current_q    <= current_d;
            acc_q        <= acc_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_idx_q     <= tx_idx_d;
            tx_shift_q   <= tx_shift_d;
            tx_hi_q      <= tx_hi_d;
            tx_lo_q      <= tx_lo_d;
            pend_valid_q <= pend_valid_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign FTDI_BDBUS_1 = tx_shift_q[0];
    // Gate with current so the pin drops the same clock the tone stops.
    assign M_HEADER     = acc_q[ACC_W-1] & (current_q != '0);
    assign M_LED_0      = led0_q;
    assign M_LED_1      = (current_q != '0);
    assign M_LED_2      = (current_q != target_q);

endmodule

// File: tb/tb_singing_fpga_sweep_top.sv
// tb_singing_fpga_sweep_top
//   Self-checking bench for singing_fpga_sweep_top with shortened timing
//   parameters. A UART monitor decodes the echo stream and compares it
//   against a queue of expected bytes pushed when words are sent.
module tb_singing_fpga_sweep_top;

    localparam int B    = 16;
    localparam int T    = 64;
    localparam int STEP = 16;
    localparam int TO   = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx, hdr, led0, led1, led2;

    singing_fpga_sweep_top #(
        .CLK_HZ      (1_000_000),
        .BAUD_DIV    (B),
        .ACC_W       (24),
        .SWEEP_TICK  (T),
        .SWEEP_STEP  (STEP),
        .WORD_TIMEOUT(TO)
    ) dut (
        .M_CLK_OSC   (clk),
        .M_RESET_B   (rst),
        .FTDI_BDBUS_0(rx),
        .FTDI_BDBUS_1(tx),
        .M_HEADER    (hdr),
        .M_LED_0     (led0),
        .M_LED_1     (led1),
        .M_LED_2     (led2)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    longint     cyc = 0;
    logic [7:0] exp_q[$];
    longint     start_q[$];
    bit         mon_en = 1'b0;
    bit         led0_exp = 1'b0;
    bit         hdr_hi_seen = 1'b0;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_target;
        logic        exp_led1;
        logic        hdr_quiet;
    } vec_t;
    vec_t vecs[5];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (hdr === 1'b1) hdr_hi_seen = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (B) @(negedge clk);
        end
        rx = stop;
        repeat (B) @(negedge clk);
        rx = 1'b1;
        repeat (B) @(negedge clk);
        if (stop) led0_exp = ~led0_exp;
    endtask

    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo);
        exp_q.push_back(8'hAC);
        exp_q.push_back(hi);
        exp_q.push_back(lo);
        send_byte(hi, 1'b1);
        send_byte(lo, 1'b1);
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("echo_drain_left", exp_q.size(), 0);
    endtask

    task automatic wait_hdr(input logic lvl, output longint t);
        int n = 0;
        while (hdr === lvl && n < 10000) begin @(negedge clk); n++; end
        while (hdr !== lvl && n < 10000) begin @(negedge clk); n++; end
        t = cyc;
        if (n >= 10000) begin
            checks++;
            errors++;
            $display("FAIL hdr_edge_timeout: got no edge to %0b, required one within 10000 cycles", lvl);
        end
    endtask

    // UART monitor / scoreboard consumer
    initial begin
        logic [7:0] rb;
        logic       stop;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                start_q.push_back(cyc);
                repeat (B / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    rb[i] = tx;
                end
                repeat (B) @(negedge clk);
                stop = tx;
                if (mon_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL echo_unexpected: got byte 0x%0h, required no byte", rb);
                    end else begin
                        chk("echo_byte", rb, exp_q.pop_front());
                    end
                    chk("echo_stop", stop, 1);
                end
            end
        end
    end

    initial begin
        #950_000;
        errors++;
        $display("FAIL watchdog: got no completion, required finish within 95000 cycles");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0, t1, r0, f0, r1, dt;

        vecs[0] = '{8'h00, 8'h00, 16'h0000, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 8'h40, 16'h0040, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h25, 16'h0025, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 8'h00, 16'h0100, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 16'h0000, 1'b0, 1'b0};

        // Reset
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_hdr", hdr, 0);
        chk("reset_led0", led0, 0);
        chk("reset_led1", led1, 0);
        chk("reset_led2", led2, 0);
        chk("reset_target", dut.target_q, 0);
        mon_en = 1'b1;

        // Table-driven words
        for (int i = 0; i < 5; i++) begin
            hdr_hi_seen = 1'b0;
            send_word(vecs[i].hi, vecs[i].lo);
            wait_drain(60 * B);
            repeat (20 * T) @(negedge clk);
            chk($sformatf("vec%0d_target", i), dut.target_q, vecs[i].exp_target);
            chk($sformatf("vec%0d_current", i), dut.current_q, vecs[i].exp_target);
            chk($sformatf("vec%0d_led1", i), led1, vecs[i].exp_led1);
            chk($sformatf("vec%0d_led2", i), led2, 0);
            chk($sformatf("vec%0d_led0", i), led0, led0_exp);
            if (vecs[i].hdr_quiet) chk($sformatf("vec%0d_hdr_quiet", i), hdr_hi_seen, 0);
        end

        // Back-to-back words: second echo must follow the first without a gap
        start_q.delete();
        send_word(8'h00, 8'h01);
        repeat (2) @(negedge clk);
        chk("b2b_target1", dut.target_q, 16'h0001);
        send_word(8'h00, 8'h02);
        repeat (2) @(negedge clk);
        chk("b2b_target2", dut.target_q, 16'h0002);
        repeat (2 * T + 2) @(negedge clk);
        chk("b2b_current", dut.current_q, 16'h0002);
        chk("b2b_led1", led1, 1);
        wait_drain(80 * B);
        chk("b2b_start_count", start_q.size(), 6);
        if (start_q.size() >= 4) begin
            chk("b2b_byte_gap", 32'(start_q[1] - start_q[0]), 10 * B);
            chk("b2b_echo_gap", 32'(start_q[3] - start_q[2]), 10 * B);
        end

        // Large sweep 0x0002 -> 0x1000 takes 256 ticks
        send_word(8'h10, 8'h00);
        t0 = cyc;
        chk("sweep_target", dut.target_q, 16'h1000);
        chk("sweep_led2_start", led2, 1);
        for (int i = 0; i < 300 * T; i++) begin
            if (led2 === 1'b0) break;
            @(negedge clk);
        end
        t1 = cyc;
        dt = t1 - t0;
        checks++;
        if (led2 !== 1'b0 || dt < 255 * T - 2 * B || dt > 256 * T) begin
            errors++;
            $display("FAIL sweep_duration: got %0d cycles (led2=%0b), required %0d..%0d with led2=0",
                     dt, led2, 255 * T - 2 * B, 256 * T);
        end
        chk("sweep_current", dut.current_q, 16'h1000);
        chk("sweep_led1", led1, 1);
        wait_drain(60 * B);

        // Oscillator period for current = 0x1000 with a 24-bit accumulator
        wait_hdr(1'b1, r0);
        wait_hdr(1'b0, f0);
        wait_hdr(1'b1, r1);
        chk("hdr_period", 32'(r1 - r0), 4096);
        chk("hdr_high_time", 32'(f0 - r0), 2048);

        // Framing error: byte dropped, no LED toggle, no echo, phase intact
        start_q.delete();
        send_byte(8'h55, 1'b0);
        repeat (20 * B) @(negedge clk);
        chk("frame_led0", led0, led0_exp);
        chk("frame_target", dut.target_q, 16'h1000);
        chk("frame_no_echo", start_q.size(), 0);
        send_word(8'h00, 8'h07);
        wait_drain(60 * B);
        chk("frame_next_target", dut.target_q, 16'h0007);

        // Word timeout: lone high byte is dropped
        send_byte(8'h12, 1'b1);
        repeat (TO + 10 * B) @(negedge clk);
        send_word(8'h00, 8'h05);
        wait_drain(60 * B);
        chk("timeout_target", dut.target_q, 16'h0005);
        chk("timeout_led0", led0, led0_exp);

        // Reset in the middle of an echo
        mon_en = 1'b0;
        send_byte(8'h00, 1'b1);
        send_byte(8'h09, 1'b1);
        for (int i = 0; i < 8 * B; i++) begin
            if (tx === 1'b0) break;
            @(negedge clk);
        end
        chk("rst_mid_tx_busy", tx, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_target", dut.target_q, 0);
        chk("rst_mid_led0", led0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_led1", led1, 0);
        chk("rst_mid_hdr", hdr, 0);
        repeat (40 * B) @(negedge clk);
        chk("rst_mid_tx_idle", tx, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
